// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard and sequencing controller for the 5-stage pipeline
//
// Drives the hold/flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB
// registers. Handles load-use stalls, taken-branch flushes (branch resolved in MEM)
// and multi-cycle data-memory waits. Also keeps a sticky memory-timeout flag and
// saturating stall/flush performance counters.
//
// Parameters:
//   TIMEOUT  max cycles spent frozen on one access before it is abandoned (>= 2)
//   CNT_W    width of stall_cnt / flush_cnt
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   MemRead_ex, Rd_ex     EX instruction is a load, and its destination register
//   Rn_id, Rm_id          ID instruction source registers
//   uses_Rm_id            ID instruction actually reads Rm
//   BrTaken_mem           branch in MEM is taken
//   mem_req_mem           MEM instruction is accessing data memory
//   mem_ready             data memory completes the access this cycle
//   stall_pc, stall_ifid, bubble_idex     load-use stall controls
//   flush_ifid, flush_idex, flush_exmem   taken-branch flush controls
//   freeze_all            hold PC and every pipeline register (memory wait)
//   mem_timeout           sticky: an access exceeded TIMEOUT cycles
//   stall_cnt, flush_cnt  saturating performance counters

module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_ex,
    input  logic [4:0]       Rd_ex,
    input  logic [4:0]       Rn_id,
    input  logic [4:0]       Rm_id,
    input  logic             uses_Rm_id,
    input  logic             BrTaken_mem,
    input  logic             mem_req_mem,
    input  logic             mem_ready,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             freeze_all,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCW = $clog2(TIMEOUT) + 1;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t         state;
    logic [WCW-1:0] wait_cnt;

    logic load_use;
    logic freeze;
    logic flush;
    logic stall;

    // X31 reads as zero, so a load targeting it never feeds a dependent instruction.
    assign load_use = MemRead_ex && (Rd_ex != 5'd31) &&
                      ((Rd_ex == Rn_id) || (uses_Rm_id && (Rd_ex == Rm_id)));

    // Controls act in the same cycle they are decided; reset forces them low
    // immediately, even while the FSM is mid-wait.
    always_comb begin
        freeze = 1'b0;
        flush  = 1'b0;
        stall  = 1'b0;
        if (!reset) begin
            if (state == MEM_WAIT) begin
                freeze = 1'b1;
            end else if (mem_req_mem && !mem_ready) begin
                freeze = 1'b1;
            end else if (BrTaken_mem) begin
                // A taken branch squashes the dependent younger instruction anyway.
                flush = 1'b1;
            end else if (load_use) begin
                stall = 1'b1;
            end
        end
    end

    assign stall_pc    = stall;
    assign stall_ifid  = stall;
    assign bubble_idex = stall;
    assign flush_ifid  = flush;
    assign flush_idex  = flush;
    assign flush_exmem = flush;
    assign freeze_all  = freeze;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            if ((freeze || stall) && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end

            case (state)
                RUN: begin
                    // The first frozen cycle happens in RUN, so the wait counter
                    // already counts it when MEM_WAIT is entered.
                    if (freeze) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WCW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
                        mem_timeout <= 1'b1;
                        state       <= RUN;
                        wait_cnt    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             MemRead_ex;
    logic [4:0]       Rd_ex;
    logic [4:0]       Rn_id;
    logic [4:0]       Rm_id;
    logic             uses_Rm_id;
    logic             BrTaken_mem;
    logic             mem_req_mem;
    logic             mem_ready;
    logic             stall_pc;
    logic             stall_ifid;
    logic             bubble_idex;
    logic             flush_ifid;
    logic             flush_idex;
    logic             flush_exmem;
    logic             freeze_all;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemRead_ex  (MemRead_ex),
        .Rd_ex       (Rd_ex),
        .Rn_id       (Rn_id),
        .Rm_id       (Rm_id),
        .uses_Rm_id  (uses_Rm_id),
        .BrTaken_mem (BrTaken_mem),
        .mem_req_mem (mem_req_mem),
        .mem_ready   (mem_ready),
        .stall_pc    (stall_pc),
        .stall_ifid  (stall_ifid),
        .bubble_idex (bubble_idex),
        .flush_ifid  (flush_ifid),
        .flush_idex  (flush_idex),
        .flush_exmem (flush_exmem),
        .freeze_all  (freeze_all),
        .mem_timeout (mem_timeout),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: "are we waiting on memory, and for how many cycles so far".
    bit m_waiting;
    int m_waited;
    bit m_to;
    int m_sc;
    int m_fc;

    // Control outputs packed as {stall_pc, stall_ifid, bubble_idex,
    // flush_ifid, flush_idex, flush_exmem, freeze_all}.
    localparam logic [6:0] C_NONE   = 7'b000_000_0;
    localparam logic [6:0] C_STALL  = 7'b111_000_0;
    localparam logic [6:0] C_FLUSH  = 7'b000_111_0;
    localparam logic [6:0] C_FREEZE = 7'b000_000_1;

    logic [6:0] obs_ctrl;

    function automatic logic [6:0] ctrl_now();
        return {stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex, flush_exmem, freeze_all};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_waiting = 1'b0;
        m_waited  = 0;
        m_to      = 1'b0;
        m_sc      = 0;
        m_fc      = 0;
    endtask

    task automatic drive_idle();
        MemRead_ex  = 1'b0;
        Rd_ex       = 5'd0;
        Rn_id       = 5'd0;
        Rm_id       = 5'd0;
        uses_Rm_id  = 1'b0;
        BrTaken_mem = 1'b0;
        mem_req_mem = 1'b0;
        mem_ready   = 1'b0;
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, "_ctrl"}, 64'(ctrl_now()), 64'(C_NONE));
        check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
        check({tag, "_flush_cnt"}, 64'(flush_cnt), 64'd0);
        check({tag, "_timeout"}, 64'(mem_timeout), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_quiet("reset");
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One clock cycle: apply inputs, compare controls against the model, clock,
    // then compare the registered state.
    task automatic cyc(input logic mr, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic um, input logic br,
                       input logic rq, input logic rdy);
        bit hazard, fr, fl, st;
        @(negedge clk);
        MemRead_ex  = mr;
        Rd_ex       = rd;
        Rn_id       = rn;
        Rm_id       = rm;
        uses_Rm_id  = um;
        BrTaken_mem = br;
        mem_req_mem = rq;
        mem_ready   = rdy;
        #1;
        hazard = mr && (rd != 5'd31) && ((rd == rn) || (um && (rd == rm)));
        if (m_waiting) begin
            fr = 1'b1; fl = 1'b0; st = 1'b0;
        end else begin
            fr = rq && !rdy;
            fl = !fr && br;
            st = !fr && !br && hazard;
        end
        obs_ctrl = ctrl_now();
        check("model_ctrl", 64'(obs_ctrl), 64'({st, st, st, fl, fl, fl, fr}));

        @(posedge clk);
        if (fr || st) m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : CNT_MAX;
        if (fl)       m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : CNT_MAX;
        if (m_waiting) begin
            if (rdy) begin
                m_waiting = 1'b0;
            end else if (m_waited + 1 >= TIMEOUT) begin
                m_to      = 1'b1;
                m_waiting = 1'b0;
            end else begin
                m_waited++;
            end
        end else if (fr) begin
            m_waiting = 1'b1;
            m_waited  = 1;
        end
        #1;
        check("model_stall_cnt", 64'(stall_cnt), 64'(m_sc));
        check("model_flush_cnt", 64'(flush_cnt), 64'(m_fc));
        check("model_timeout", 64'(mem_timeout), 64'(m_to));
    endtask

    typedef struct {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       um;
        logic       br;
        logic       rq;
        logic       rdy;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int fz;
        reset = 1'b1;
        drive_idle();

        vecs[0] = '{1'b1, 5'd1,  5'd1,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, C_STALL, "lu_rn"};
        vecs[1] = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  "xzr"};
        vecs[2] = '{1'b1, 5'd5,  5'd0,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, C_NONE,  "rm_unused"};
        vecs[3] = '{1'b1, 5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, C_STALL, "lu_rm"};
        vecs[4] = '{1'b0, 5'd5,  5'd5,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  "not_load"};
        vecs[5] = '{1'b1, 5'd1,  5'd1,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, C_FLUSH, "br_over_lu"};
        vecs[6] = '{1'b1, 5'd2,  5'd2,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, C_FLUSH, "br_mem_done"};
        vecs[7] = '{1'b1, 5'd3,  5'd0,  5'd3,  1'b1, 1'b0, 1'b0, 1'b1, C_STALL, "rdy_no_req"};
        vecs[8] = '{1'b1, 5'd4,  5'd7,  5'd8,  1'b1, 1'b0, 1'b0, 1'b0, C_NONE,  "lu_no_match"};
        vecs[9] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, C_NONE,  "mem_one_cycle"};

        // Reset state
        #2;
        check_all_quiet("init");
        do_reset();

        // Single-cycle RUN-state decisions
        foreach (vecs[i]) begin
            cyc(vecs[i].mr, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].um,
                vecs[i].br, vecs[i].rq, vecs[i].rdy);
            check({"vec_", vecs[i].name}, 64'(obs_ctrl), 64'(vecs[i].exp));
        end

        // Load-use from fresh reset counts one stall cycle
        do_reset();
        cyc(1'b1, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_ctrl", 64'(obs_ctrl), 64'(C_STALL));
        check("t1_stall_cnt", 64'(stall_cnt), 64'd1);

        // Branch with load-use present: flush only, one flush counted
        do_reset();
        cyc(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_ctrl", 64'(obs_ctrl), 64'(C_FLUSH));
        check("t3_flush_cnt", 64'(flush_cnt), 64'd1);
        check("t3_stall_cnt", 64'(stall_cnt), 64'd0);

        // Memory ready after 3 cycles: four frozen cycles, branch flush afterwards
        do_reset();
        fz = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 5'd1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            if (obs_ctrl == C_FREEZE) fz++;
        end
        cyc(1'b1, 5'd1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        if (obs_ctrl == C_FREEZE) fz++;
        check("t4_freeze_cycles", 64'(fz), 64'd4);
        check("t4_stall_cnt", 64'(stall_cnt), 64'd4);
        cyc(1'b1, 5'd1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t4_flush_after_wait", 64'(obs_ctrl), 64'(C_FLUSH));

        // Memory never ready: freeze for TIMEOUT cycles, sticky timeout
        do_reset();
        fz = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (obs_ctrl == C_FREEZE) fz++;
            if (i == TIMEOUT - 2) check("t5_timeout_early", 64'(mem_timeout), 64'd0);
        end
        check("t5_freeze_cycles", 64'(fz), 64'(TIMEOUT));
        check("t5_timeout", 64'(mem_timeout), 64'd1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_timeout_sticky", 64'(mem_timeout), 64'd1);
        check("t5_run_after", 64'(obs_ctrl), 64'(C_NONE));

        // Asynchronous reset in the middle of a wait
        for (int i = 0; i < 3; i++) cyc(1'b1, 5'd1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t6_frozen_before", 64'(obs_ctrl), 64'(C_FREEZE));
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_quiet("t6_midwait");
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_run_idle", 64'(obs_ctrl), 64'(C_NONE));
        cyc(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_run_stall", 64'(obs_ctrl), 64'(C_STALL));

        // Saturation of stall_cnt
        do_reset();
        for (int i = 0; i < CNT_MAX + 8; i++) cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("sat_stall_cnt", 64'(stall_cnt), 64'(CNT_MAX));

        // Saturation of flush_cnt
        do_reset();
        for (int i = 0; i < CNT_MAX + 8; i++) cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("sat_flush_cnt", 64'(flush_cnt), 64'(CNT_MAX));

        // Randomized stimulus against the reference model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [4:0] regs[4];
            regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd3; regs[3] = 5'd31;
            cyc(1'($urandom_range(0, 1)),
                regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
